// File: rtl/clock_tick_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : clock_tick_sequencer_if
// Brief   : Bus between the tick sequencer and the six BCD digit counters.
// Revision: 1.0 - initial release
// ============================================================================
interface clock_tick_sequencer_if;
    logic [23:0] digits;      // {h1,h0,m1,m0,s1,s0}, s0 in [3:0]
    logic [5:0]  digit_en;    // bit 5 = h1 ... bit 0 = s0
    logic [5:0]  digit_load;
    logic [23:0] load_val;
    logic        cnt_dir;

    modport master (
        input  digits,
        output digit_en,
        output digit_load,
        output load_val,
        output cnt_dir
    );

    modport slave (
        output digits,
        input  digit_en,
        input  digit_load,
        input  load_val,
        input  cnt_dir
    );
endinterface
`default_nettype wire

// File: rtl/clock_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : clock_tick_sequencer
// Brief   : 1 Hz prescaler, 24 h up/down rollover decisions and RUN/SET mode
//           FSM driving six BCD digit counters through load/step pulses.
// Revision: 1.0 - initial release
// ============================================================================
module clock_tick_sequencer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   btn_mode,
    input  wire logic                   btn_adj,
    input  wire logic                   dir,
    input  wire logic                   pause,
    clock_tick_sequencer_if.master      cnt,
    output logic [1:0]                  mode,
    output logic                        timer_done
);

    localparam int              c_pw  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_top = c_pw'(TICK_DIV - 1);
    localparam logic [c_pw-1:0] c_one = c_pw'(1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SET_HR  = 2'd1,
        S_SET_MIN = 2'd2,
        S_SET_SEC = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_pw-1:0] r_presc;
    logic            r_halted;
    logic            r_busy;

    // Button path, bit 0 = mode, bit 1 = adjust
    logic [1:0] r_btn_sync0;
    logic [1:0] r_btn_sync1;
    logic [1:0] r_btn_prev;
    logic [1:0] r_btn_pulse;

    logic [5:0]  r_digit_en;
    logic [5:0]  r_digit_load;
    logic [23:0] r_load_val;
    logic        r_cnt_dir;
    logic        r_timer_done;

    logic [3:0] w_s0, w_s1, w_m0, w_m1, w_h0, w_h1;
    logic       w_run_cnt;
    logic       w_tick;
    logic       w_adj;
    logic       w_mode_edge;
    logic       w_all_zero;
    logic       w_b1, w_b2, w_b3, w_b4;

    logic [5:0]  w_en;
    logic [5:0]  w_ld;
    logic [23:0] w_val;
    logic        w_dir;
    logic        w_fire;
    logic        w_done;
    logic        w_up_sec;
    logic        w_up_min;
    logic        w_up_hr;

    assign {w_h1, w_h0, w_m1, w_m0, w_s1, w_s0} = cnt.digits;

    assign w_mode_edge = r_btn_pulse[0];
    assign w_run_cnt   = (r_state == S_RUN) && !pause && !r_halted;
    assign w_tick      = w_run_cnt && (r_presc == c_top);
    // An adjust edge right after a step would see digits that have not settled yet
    assign w_adj       = r_btn_pulse[1] && (r_state != S_RUN) && !r_busy;
    assign w_all_zero  = (cnt.digits == 24'd0);

    assign w_b1 = (w_s0 == 4'd0);
    assign w_b2 = w_b1 && (w_s1 == 4'd0);
    assign w_b3 = w_b2 && (w_m0 == 4'd0);
    assign w_b4 = w_b3 && (w_m1 == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_sync0 <= 2'b00;
            r_btn_sync1 <= 2'b00;
            r_btn_prev  <= 2'b00;
            r_btn_pulse <= 2'b00;
        end else begin
            r_btn_sync0 <= {btn_adj, btn_mode};
            r_btn_sync1 <= r_btn_sync0;
            r_btn_prev  <= r_btn_sync1;
            r_btn_pulse <= r_btn_sync1 & ~r_btn_prev;
        end
    end

    always_comb begin
        w_en     = 6'd0;
        w_ld     = 6'd0;
        w_val    = 24'd0;
        w_dir    = 1'b0;
        w_fire   = 1'b0;
        w_done   = 1'b0;
        w_up_sec = 1'b0;
        w_up_min = 1'b0;
        w_up_hr  = 1'b0;

        if (w_tick && !dir) begin
            w_fire   = 1'b1;
            w_up_sec = 1'b1;
            w_up_min = (w_s0 == 4'd9) && (w_s1 == 4'd5);
            w_up_hr  = w_up_min && (w_m0 == 4'd9) && (w_m1 == 4'd5);
        end else if (w_tick && w_all_zero) begin
            w_done = 1'b1;
        end else if (w_tick) begin
            w_fire = 1'b1;
            w_dir  = 1'b1;
            if (w_b1) begin
                w_ld[0]     = 1'b1;
                w_val[3:0]  = 4'd9;
            end else begin
                w_en[0]     = 1'b1;
            end
            if (w_b1) begin
                if (w_s1 == 4'd0) begin
                    w_ld[1]    = 1'b1;
                    w_val[7:4] = 4'd5;
                end else begin
                    w_en[1]    = 1'b1;
                end
            end
            if (w_b2) begin
                if (w_m0 == 4'd0) begin
                    w_ld[2]     = 1'b1;
                    w_val[11:8] = 4'd9;
                end else begin
                    w_en[2]     = 1'b1;
                end
            end
            if (w_b3) begin
                if (w_m1 == 4'd0) begin
                    w_ld[3]      = 1'b1;
                    w_val[15:12] = 4'd5;
                end else begin
                    w_en[3]      = 1'b1;
                end
            end
            if (w_b4) begin
                if ((w_h1 == 4'd0) && (w_h0 == 4'd0)) begin
                    w_ld[5:4]    = 2'b11;
                    w_val[23:20] = 4'd2;
                    w_val[19:16] = 4'd3;
                end else if (w_h0 == 4'd0) begin
                    w_ld[4]      = 1'b1;
                    w_val[19:16] = 4'd9;
                    w_en[5]      = 1'b1;
                end else begin
                    w_en[4]      = 1'b1;
                end
            end
        end else if (w_adj) begin
            w_fire = 1'b1;
            case (r_state)
                S_SET_HR:  w_up_hr  = 1'b1;
                S_SET_MIN: w_up_min = 1'b1;
                S_SET_SEC: w_up_sec = 1'b1;
                default:   w_fire   = 1'b0;
            endcase
        end

        // Upward wraps always load zero, so load_val stays at its default here
        if (w_up_sec) begin
            if (w_s0 == 4'd9) begin
                w_ld[0] = 1'b1;
                if (w_s1 == 4'd5) w_ld[1] = 1'b1;
                else              w_en[1] = 1'b1;
            end else begin
                w_en[0] = 1'b1;
            end
        end
        if (w_up_min) begin
            if (w_m0 == 4'd9) begin
                w_ld[2] = 1'b1;
                if (w_m1 == 4'd5) w_ld[3] = 1'b1;
                else              w_en[3] = 1'b1;
            end else begin
                w_en[2] = 1'b1;
            end
        end
        if (w_up_hr) begin
            if ((w_h1 == 4'd2) && (w_h0 == 4'd3)) begin
                w_ld[5:4] = 2'b11;
            end else if (w_h0 == 4'd9) begin
                w_ld[4] = 1'b1;
                w_en[5] = 1'b1;
            end else begin
                w_en[4] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_presc  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_mode_edge) begin
                case (r_state)
                    S_RUN:     r_state <= S_SET_HR;
                    S_SET_HR:  r_state <= S_SET_MIN;
                    S_SET_MIN: r_state <= S_SET_SEC;
                    S_SET_SEC: r_state <= S_RUN;
                    default:   r_state <= S_RUN;
                endcase
            end

            if (w_mode_edge && (r_state == S_SET_SEC)) begin
                r_presc <= '0;
            end else if (w_run_cnt) begin
                r_presc <= (r_presc == c_top) ? '0 : r_presc + c_one;
            end

            if (w_mode_edge || !dir) begin
                r_halted <= 1'b0;
            end else if (w_done) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit_en   <= 6'd0;
            r_digit_load <= 6'd0;
            r_load_val   <= 24'd0;
            r_cnt_dir    <= 1'b0;
            r_timer_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_digit_en   <= w_en;
            r_digit_load <= w_ld;
            r_load_val   <= w_val;
            r_cnt_dir    <= w_fire & w_dir;
            r_timer_done <= w_done;
            r_busy       <= w_fire;
        end
    end

    assign cnt.digit_en   = r_digit_en;
    assign cnt.digit_load = r_digit_load;
    assign cnt.load_val   = r_load_val;
    assign cnt.cnt_dir    = r_cnt_dir;
    assign mode           = r_state;
    assign timer_done     = r_timer_done;

endmodule
`default_nettype wire

// File: tb/tb_clock_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_tick_sequencer
// Brief   : Directed scoreboard bench for clock_tick_sequencer (TICK_DIV=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clock_tick_sequencer;

    localparam int TD = 4;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       btn_mode  = 1'b0;
    logic       btn_adj   = 1'b0;
    logic       dir       = 1'b0;
    logic       pause     = 1'b1;
    logic [1:0] mode;
    logic       timer_done;

    clock_tick_sequencer_if bus();

    clock_tick_sequencer #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_adj    (btn_adj),
        .dir        (dir),
        .pause      (pause),
        .cnt        (bus),
        .mode       (mode),
        .timer_done (timer_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;
    int n_obs    = 0;
    int n_exp    = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [5:0]  en;
        logic [5:0]  ld;
        logic [23:0] val;
        logic        cd;
        logic        done;
        bit          chk_dir;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_step(input string tag, input int at, input logic [5:0] en,
                               input logic [5:0] ld, input logic [23:0] val,
                               input logic cd, input logic done);
        exp_t e;
        e.cyc     = at;
        e.tag     = tag;
        e.en      = en;
        e.ld      = ld;
        e.val     = val;
        e.cd      = cd;
        e.done    = done;
        e.chk_dir = !done;
        sb.push_back(e);
        n_exp++;
    endtask

    // Any step activity on the bus must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset && ((bus.digit_en != 6'd0) || (bus.digit_load != 6'd0) || timer_done)) begin
            exp_t e;
            n_obs++;
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "_cyc"},  32'(cyc),            32'(e.cyc));
                chk({e.tag, "_en"},   32'(bus.digit_en),   32'(e.en));
                chk({e.tag, "_load"}, 32'(bus.digit_load), 32'(e.ld));
                chk({e.tag, "_val"},  32'(bus.load_val),   32'(e.val));
                chk({e.tag, "_done"}, 32'(timer_done),     32'(e.done));
                if (e.chk_dir) chk({e.tag, "_dir"}, 32'(bus.cnt_dir), 32'(e.cd));
            end
        end
    end

    task automatic tick_step(input string tag, input logic [23:0] d, input logic dr,
                             input logic [5:0] en, input logic [5:0] ld,
                             input logic [23:0] val, input logic done);
        bus.digits = d;
        dir        = dr;
        expect_step(tag, cyc + TD, en, ld, val, dr, done);
        pause = 1'b0;
        repeat (TD) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
    endtask

    task automatic press_mode(input logic [1:0] from_m, input logic [1:0] to_m);
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("mode_hold", 32'(mode), 32'(from_m));
        @(negedge clk);
        chk("mode_next", 32'(mode), 32'(to_m));
        repeat (2) @(negedge clk);
        btn_mode = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_adj(input string tag, input logic [23:0] d,
                             input logic [5:0] en, input logic [5:0] ld);
        bus.digits = d;
        expect_step(tag, cyc + 4, en, ld, 24'd0, 1'b0, 1'b0);
        btn_adj = 1'b1;
        repeat (6) @(negedge clk);
        btn_adj = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int j;
        bus.digits = 24'd0;
        repeat (3) @(negedge clk);
        chk("rst_en",   32'(bus.digit_en),   32'd0);
        chk("rst_load", 32'(bus.digit_load), 32'd0);
        chk("rst_val",  32'(bus.load_val),   32'd0);
        chk("rst_dir",  32'(bus.cnt_dir),    32'd0);
        chk("rst_mode", 32'(mode),           32'd0);
        chk("rst_done", 32'(timer_done),     32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        tick_step("up_235959", 24'h235959, 1'b0, 6'h00, 6'h3F, 24'h000000, 1'b0);
        tick_step("up_095959", 24'h095959, 1'b0, 6'h20, 6'h1F, 24'h000000, 1'b0);
        tick_step("up_123456", 24'h123456, 1'b0, 6'h01, 6'h00, 24'h000000, 1'b0);
        tick_step("up_123559", 24'h123559, 1'b0, 6'h04, 6'h03, 24'h000000, 1'b0);
        tick_step("dn_100000", 24'h100000, 1'b1, 6'h20, 6'h1F, 24'h095959, 1'b0);
        tick_step("dn_123000", 24'h123000, 1'b1, 6'h08, 6'h07, 24'h000959, 1'b0);
        tick_step("dn_130000", 24'h130000, 1'b1, 6'h10, 6'h0F, 24'h005959, 1'b0);
        tick_step("dn_000000", 24'h000000, 1'b1, 6'h00, 6'h00, 24'h000000, 1'b1);

        // Halted countdown: no further ticks until the direction flips to up
        pause = 1'b0;
        repeat (12) @(negedge clk);
        chk("halt_suppress", 32'(n_obs), 32'(n_exp));
        j   = cyc;
        dir = 1'b0;
        expect_step("halt_release", j + 5, 6'h01, 6'h00, 24'h0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);

        // Pause mid-count: the held count resumes, four counted cycles per tick
        bus.digits = 24'h000005;
        j = cyc;
        expect_step("pause_resume", j + 14, 6'h01, 6'h00, 24'h0, 1'b0, 1'b0);
        pause = 1'b0;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        pause = 1'b0;
        repeat (2) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        chk("steps_after_pause", 32'(n_obs), 32'(n_exp));

        press_mode(2'd0, 2'd1);
        press_adj("set_hr_23", 24'h231234, 6'h00, 6'h30);
        press_mode(2'd1, 2'd2);
        press_adj("set_min_45", 24'h124512, 6'h04, 6'h00);
        press_mode(2'd2, 2'd3);
        press_adj("set_sec_59", 24'h123459, 6'h00, 6'h03);
        press_mode(2'd3, 2'd0);
        chk("steps_after_set", 32'(n_obs), 32'(n_exp));

        // Mode edge lands on the tick cycle; the adjust edge one cycle later is dropped
        bus.digits = 24'h000001;
        dir        = 1'b0;
        j          = cyc;
        expect_step("busy_tick", j + 4, 6'h01, 6'h00, 24'h0, 1'b0, 1'b0);
        pause    = 1'b0;
        btn_mode = 1'b1;
        @(negedge clk);
        btn_adj = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b1;
        chk("busy_mode", 32'(mode), 32'd1);
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        btn_adj  = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_adj_dropped", 32'(n_obs), 32'(n_exp));

        // Reset lands just after a step has been registered
        bus.digits = 24'h120000;
        btn_adj    = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_en",   32'(bus.digit_en),   32'd0);
        chk("rst_mid_load", 32'(bus.digit_load), 32'd0);
        chk("rst_mid_val",  32'(bus.load_val),   32'd0);
        chk("rst_mid_dir",  32'(bus.cnt_dir),    32'd0);
        chk("rst_mid_done", 32'(timer_done),     32'd0);
        chk("rst_mid_mode", 32'(mode),           32'd0);
        btn_adj = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_no_partial", 32'(n_obs), 32'(n_exp));
        chk("rst_mode_after", 32'(mode), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
